// File: rtl/i2s_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : i2s_pkg
// Purpose  : Shared types and defaults for the I2S microphone receive path.
//            Holds the receive-controller state encoding, the stereo pair
//            container and the clock-generator-matching defaults.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package i2s_pkg;

    // Defaults that must agree with i2s_clock_gen
    localparam int   I2S_SCKS_PER_HALF_DEF = 32;
    localparam logic I2S_WS_POL_DEF        = 1'b0;

    // Widest channel word carried by i2s_pair_t; DATA_W must not exceed it
    localparam int   I2S_MAX_DATA_W        = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_ALIGN   = 2'd2,
        ST_CAPTURE = 2'd3
    } i2s_rx_state_e;

    typedef struct packed {
        logic [I2S_MAX_DATA_W-1:0] left;
        logic [I2S_MAX_DATA_W-1:0] right;
    } i2s_pair_t;

    // True when the WS level selects the left channel
    function automatic logic ws_is_left(input logic ws, input logic pol);
        return (ws == pol);
    endfunction

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_rx_deser.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : i2s_rx_deser
// Purpose  : I2S bit-level deserializer. Detects SCK rising edges, tracks the
//            WS level and bit position, shifts MSB-first words into per-channel
//            registers and pulses pair_ready_o when a complete left/right pair
//            is closed by a WS change back to the left channel.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int   DATA_W        = 24,
    parameter int   SCKS_PER_HALF = I2S_SCKS_PER_HALF_DEF,
    parameter logic WS_POL        = I2S_WS_POL_DEF
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      capture_i,     // 0: hold in frame-aligned start state
    input  logic      sck_i,
    input  logic      ws_i,
    input  logic      sd_i,
    output logic      pair_ready_o,
    output i2s_pair_t pair_o
);

    localparam int                c_IDX_W    = $clog2(SCKS_PER_HALF + 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX  = c_IDX_W'(SCKS_PER_HALF);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_W);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    logic                sck_d_q;
    logic                ws_last_q, ws_last_d;
    logic [c_IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic                l_done_q, l_done_d;
    logic                r_done_q, r_done_d;
    logic [DATA_W-1:0]   l_sh_q, l_sh_d;
    logic [DATA_W-1:0]   r_sh_q, r_sh_d;

    logic                w_sck_rise;
    logic                w_ws_change;
    logic                w_left;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_in_word;
    logic [DATA_W-1:0]   w_l_shift;
    logic [DATA_W-1:0]   w_r_shift;

    // Shifted versions of each channel register with sd_i entering at the LSB
    if (DATA_W > 1) begin : g_shift_multi
        assign w_l_shift = {l_sh_q[DATA_W-2:0], sd_i};
        assign w_r_shift = {r_sh_q[DATA_W-2:0], sd_i};
    end else begin : g_shift_single
        assign w_l_shift = sd_i;
        assign w_r_shift = sd_i;
    end

    assign w_sck_rise  = sck_i & ~sck_d_q;
    assign w_ws_change = (ws_i != ws_last_q);
    assign w_left      = ws_is_left(ws_i, WS_POL);
    // Slot 0 after a WS change carries the previous word's LSB and is skipped
    assign w_idx       = w_ws_change ? '0 : bit_idx_q;
    assign w_in_word   = (w_idx != '0) && (w_idx <= c_IDX_LAST);

    assign pair_o.left  = I2S_MAX_DATA_W'(l_sh_q);
    assign pair_o.right = I2S_MAX_DATA_W'(r_sh_q);

    // Next-state for bit tracking, shift registers, done flags and pair pulse
    always_comb begin
        ws_last_d    = ws_last_q;
        bit_idx_d    = bit_idx_q;
        l_done_d     = l_done_q;
        r_done_d     = r_done_q;
        l_sh_d       = l_sh_q;
        r_sh_d       = r_sh_q;
        pair_ready_o = 1'b0;

        if (!capture_i) begin
            // Start state assumes the last WS seen was the right channel so the
            // first left edge is treated as a channel change.
            ws_last_d = ~WS_POL;
            bit_idx_d = '0;
            l_done_d  = 1'b0;
            r_done_d  = 1'b0;
        end else if (w_sck_rise) begin
            if (w_ws_change) begin
                bit_idx_d = c_IDX_ONE;
                ws_last_d = ws_i;
                if (w_left) begin
                    pair_ready_o = l_done_q & r_done_q;
                    l_done_d     = 1'b0;
                    r_done_d     = 1'b0;
                end
            end else if (bit_idx_q != c_IDX_MAX) begin
                bit_idx_d = bit_idx_q + c_IDX_ONE;
            end

            if (w_in_word) begin
                if (w_left) begin
                    l_sh_d = w_l_shift;
                end else begin
                    r_sh_d = w_r_shift;
                end
            end

            if (w_idx == c_IDX_LAST) begin
                if (w_left) begin
                    l_done_d = 1'b1;
                end else begin
                    r_done_d = 1'b1;
                end
            end
        end
    end

    // Deserializer state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_d_q   <= 1'b0;
            ws_last_q <= ~WS_POL;
            bit_idx_q <= '0;
            l_done_q  <= 1'b0;
            r_done_q  <= 1'b0;
            l_sh_q    <= '0;
            r_sh_q    <= '0;
        end else begin
            sck_d_q   <= sck_i;
            ws_last_q <= ws_last_d;
            bit_idx_q <= bit_idx_d;
            l_done_q  <= l_done_d;
            r_done_q  <= r_done_d;
            l_sh_q    <= l_sh_d;
            r_sh_q    <= r_sh_d;
        end
    end

endmodule : i2s_rx_deser
`default_nettype wire

// File: rtl/i2s_rx_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : i2s_rx_ctrl
// Purpose  : I2S microphone receive sequencer. Holds the clock generator in
//            reset while idle, discards WARMUP_FRAMES frames after enable,
//            aligns to a frame start and delivers stereo pairs over a
//            valid/ready handshake with sticky overflow reporting.
// Options  : `I2S_RX_CTRL_STATS_EN builds committed/dropped pair counters;
//            without it frame_count_o and drop_count_o are tied to zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module i2s_rx_ctrl
    import i2s_pkg::*;
#(
    parameter int   DATA_W        = 24,
    parameter int   SCKS_PER_HALF = I2S_SCKS_PER_HALF_DEF,
    parameter logic WS_POL        = I2S_WS_POL_DEF,
    parameter int   WARMUP_FRAMES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              clear_ovf_i,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic              frame_start_i,
    input  logic              sd_i,
    output logic              clkgen_rst_no,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic [DATA_W-1:0] left_o,
    output logic [DATA_W-1:0] right_o,
    output logic              overflow_o,
    output logic [1:0]        state_o,
    output logic [15:0]       frame_count_o,
    output logic [15:0]       drop_count_o
);

    localparam int                  c_WCNT_W   = $clog2(WARMUP_FRAMES + 1);
    localparam logic [c_WCNT_W-1:0] c_WARM_TGT = c_WCNT_W'(WARMUP_FRAMES);
    localparam logic [c_WCNT_W-1:0] c_WARM_ONE = c_WCNT_W'(1);

    i2s_rx_state_e        state_q, state_d;
    logic [c_WCNT_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic                 clkgen_q;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    i2s_pair_t            pair_q, pair_d;

    logic                 w_pair_ready;
    i2s_pair_t            w_pair;
    logic                 w_disable;
    logic                 w_commit;
    logic                 w_accept;
    logic                 w_drop;
    logic [c_WCNT_W-1:0]  w_warm_inc;

    i2s_rx_deser #(
        .DATA_W        (DATA_W),
        .SCKS_PER_HALF (SCKS_PER_HALF),
        .WS_POL        (WS_POL)
    ) u_deser (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .capture_i     (state_q == ST_CAPTURE),
        .sck_i         (sck_i),
        .ws_i          (ws_i),
        .sd_i          (sd_i),
        .pair_ready_o  (w_pair_ready),
        .pair_o        (w_pair)
    );

    assign w_disable  = (state_q != ST_IDLE) && !enable_i;
    assign w_commit   = w_pair_ready && (state_q == ST_CAPTURE) && !w_disable;
    assign w_accept   = w_commit && (!valid_q || sample_ready_i);
    assign w_drop     = w_commit && !w_accept;
    assign w_warm_inc = warm_cnt_q + c_WARM_ONE;

    // FSM next-state and warm-up frame counting
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (frame_start_i) begin
                    warm_cnt_d = w_warm_inc;
                    if (w_warm_inc == c_WARM_TGT) begin
                        state_d = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                if (frame_start_i) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_CAPTURE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_disable) begin
            state_d = ST_IDLE;
        end

        // The counter only carries a value while warming up
        if (state_d != ST_WARMUP) begin
            warm_cnt_d = '0;
        end
    end

    // FSM state register and clock-generator reset (lags the state by a cycle)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            warm_cnt_q <= '0;
            clkgen_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            clkgen_q   <= (state_q != ST_IDLE);
        end
    end

    // Handshake, held pair and sticky overflow next-state
    always_comb begin
        valid_d = valid_q;
        pair_d  = pair_q;
        ovf_d   = ovf_q;

        if (valid_q && sample_ready_i) begin
            valid_d = 1'b0;
        end
        if (w_accept) begin
            pair_d  = w_pair;
            valid_d = 1'b1;
        end
        if (w_disable) begin
            valid_d = 1'b0;
        end

        // A drop in the same cycle as a clear leaves the flag set
        if (clear_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (w_drop) begin
            ovf_d = 1'b1;
        end
    end

    // Handshake, held pair and overflow registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pair_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pair_q  <= pair_d;
            ovf_q   <= ovf_d;
        end
    end

    // Bits of the shared pair container above DATA_W are never driven non-zero
    if (DATA_W < I2S_MAX_DATA_W) begin : g_pair_pad
        logic w_unused_pad;
        assign w_unused_pad = ^{pair_q.left[I2S_MAX_DATA_W-1:DATA_W],
                                pair_q.right[I2S_MAX_DATA_W-1:DATA_W]};
    end

`ifdef I2S_RX_CTRL_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;

    // Committed and dropped pair counters, wrapping at 2^16
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (w_accept) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (w_drop) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign frame_count_o = frame_cnt_q;
    assign drop_count_o  = drop_cnt_q;
`else
    assign frame_count_o = '0;
    assign drop_count_o  = '0;
`endif

    assign clkgen_rst_no  = clkgen_q;
    assign sample_valid_o = valid_q;
    assign left_o         = pair_q.left[DATA_W-1:0];
    assign right_o        = pair_q.right[DATA_W-1:0];
    assign overflow_o     = ovf_q;
    assign state_o        = state_q;

endmodule : i2s_rx_ctrl
`default_nettype wire

// File: tb/tb_i2s_rx_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_i2s_rx_ctrl
// Purpose  : Directed self-checking bench for i2s_rx_ctrl with a behavioural
//            clock generator (8 clk per SCK, 32 SCK per half frame) and a
//            microphone model sending fixed left/right words every frame.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_i2s_rx_ctrl;

    localparam int DATA_W = 24;
`ifdef I2S_RX_CTRL_STATS_EN
    localparam int c_STATS = 1;
`else
    localparam int c_STATS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_i, enable_i, clear_ovf_i;
    logic              sck_i, ws_i, frame_start_i, sd_i;
    logic              clkgen_rst_no, sample_valid_o, sample_ready_i;
    logic [DATA_W-1:0] left_o, right_o;
    logic              overflow_o;
    logic [1:0]        state_o;
    logic [15:0]       frame_count_o, drop_count_o;

    int checks = 0;
    int fails  = 0;

    // Clock-generator / microphone model state
    int                ph, s;
    logic [DATA_W-1:0] mic_l = 24'h123456;
    logic [DATA_W-1:0] mic_r = 24'hFEDCBA;
    int                t1_stamp;

    i2s_rx_ctrl #(
        .DATA_W        (DATA_W),
        .SCKS_PER_HALF (32),
        .WS_POL        (1'b0),
        .WARMUP_FRAMES (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .clear_ovf_i    (clear_ovf_i),
        .sck_i          (sck_i),
        .ws_i           (ws_i),
        .frame_start_i  (frame_start_i),
        .sd_i           (sd_i),
        .clkgen_rst_no  (clkgen_rst_no),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .left_o         (left_o),
        .right_o        (right_o),
        .overflow_o     (overflow_o),
        .state_o        (state_o),
        .frame_count_o  (frame_count_o),
        .drop_count_o   (drop_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic mic_bit(input int slot);
        if (slot >= 1 && slot <= 24)  return mic_l[24 - slot];
        if (slot >= 33 && slot <= 56) return mic_r[56 - slot];
        return 1'b0;
    endfunction

    // Clock generator + mic: WS/SD change with SCK falling, frame_start at slot 0
    initial begin
        ph = 7; s = 63;
        sck_i = 1'b0; ws_i = 1'b1; frame_start_i = 1'b0; sd_i = 1'b0;
        forever begin
            @(negedge clk);
            if (clkgen_rst_no !== 1'b1) begin
                ph = 7; s = 63;
                sck_i = 1'b0; ws_i = 1'b1; frame_start_i = 1'b0; sd_i = 1'b0;
            end else begin
                ph = (ph + 1) % 8;
                if (ph == 0) s = (s + 1) % 64;
                sck_i         = (ph >= 4);
                frame_start_i = (ph == 0) && (s == 0);
                if (ph == 0) begin
                    ws_i = (s >= 32);
                    sd_i = mic_bit(s);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frame_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if (frame_start_i === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; enable_i = 1'b0; clear_ovf_i = 1'b0; sample_ready_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (state_o !== 2'd0 || clkgen_rst_no !== 1'b0 || sample_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: state=%0d clkgen=%b valid=%b ovf=%b, required 0 0 0 0",
                     state_o, clkgen_rst_no, sample_valid_o, overflow_o);
        end
        checks++;
        if (left_o !== 24'h0 || right_o !== 24'h0 || frame_count_o !== 16'h0 || drop_count_o !== 16'h0) begin
            fails++;
            $display("FAIL reset_data: left=%h right=%h fc=%0d dc=%0d, required all 0",
                     left_o, right_o, frame_count_o, drop_count_o);
        end
        rst_i = 1'b0;
        tick();
        checks++;
        if (state_o !== 2'd0) begin
            fails++;
            $display("FAIL idle_hold: state=%0d, required 0", state_o);
        end
    endtask

    task automatic test_enable_warmup();
        bit ok;
        enable_i = 1'b1;
        tick();
        checks++;
        if (state_o !== 2'd1 || clkgen_rst_no !== 1'b0) begin
            fails++;
            $display("FAIL enable_entry: state=%0d clkgen=%b, required 1 0", state_o, clkgen_rst_no);
        end
        tick();
        checks++;
        if (clkgen_rst_no !== 1'b1) begin
            fails++;
            $display("FAIL clkgen_release: clkgen=%b, required 1", clkgen_rst_no);
        end
        for (int p = 1; p <= 3; p++) begin
            wait_frame_start(ok);
            tick();
            checks++;
            if (!ok || state_o !== 2'(p)) begin
                fails++;
                $display("FAIL warmup_seq%0d: seen=%b state=%0d, required 1 %0d", p, ok, state_o, p);
            end
        end
    endtask

    task automatic test_first_pair(input logic [DATA_W-1:0] exp_l, input logic [DATA_W-1:0] exp_r);
        int n;
        n = 1;
        while (sample_valid_o !== 1'b1 && n < 700) begin
            tick();
            n++;
        end
        checks++;
        if (n != 517) begin
            fails++;
            $display("FAIL first_latency: valid seen after %0d cycles, required 517", n);
        end
        checks++;
        if (sample_valid_o !== 1'b1 || left_o !== exp_l || right_o !== exp_r) begin
            fails++;
            $display("FAIL first_pair: valid=%b left=%h right=%h, required 1 %h %h",
                     sample_valid_o, left_o, right_o, exp_l, exp_r);
        end
        t1_stamp = n;
    endtask

    task automatic test_overflow();
        // New words from the next frame on; held pair must not change
        mic_l = 24'hABCDEF;
        mic_r = 24'h0F0F0F;
        repeat (1030) tick();
        checks++;
        if (sample_valid_o !== 1'b1 || left_o !== 24'h123456 || right_o !== 24'hFEDCBA) begin
            fails++;
            $display("FAIL ovf_retain: valid=%b left=%h right=%h, required 1 123456 fedcba",
                     sample_valid_o, left_o, right_o);
        end
        checks++;
        if (overflow_o !== 1'b1 || drop_count_o !== 16'(2 * c_STATS) || frame_count_o !== 16'(c_STATS)) begin
            fails++;
            $display("FAIL ovf_flag: ovf=%b dc=%0d fc=%0d, required 1 %0d %0d",
                     overflow_o, drop_count_o, frame_count_o, 2 * c_STATS, c_STATS);
        end
        clear_ovf_i = 1'b1;
        tick();
        clear_ovf_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b, required 0", overflow_o);
        end
    endtask

    task automatic test_back_to_back();
        int pulses, run, max_run;
        sample_ready_i = 1'b1;
        tick();
        checks++;
        if (sample_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL transfer_drop: valid=%b, required 0", sample_valid_o);
        end
        pulses = 0; run = 0; max_run = 0;
        for (int i = 0; i < 1536; i++) begin
            tick();
            if (sample_valid_o === 1'b1) begin
                run++;
                if (run == 1) pulses++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        checks++;
        if (pulses != 3 || max_run != 1) begin
            fails++;
            $display("FAIL b2b_pulses: pulses=%0d longest=%0d, required 3 1", pulses, max_run);
        end
        checks++;
        if (left_o !== 24'hABCDEF || right_o !== 24'h0F0F0F || frame_count_o !== 16'(4 * c_STATS)) begin
            fails++;
            $display("FAIL b2b_data: left=%h right=%h fc=%0d, required abcdef 0f0f0f %0d",
                     left_o, right_o, frame_count_o, 4 * c_STATS);
        end
        sample_ready_i = 1'b0;
    endtask

    task automatic test_disable();
        int n;
        n = 0;
        while (sample_valid_o !== 1'b1 && n < 700) begin
            tick();
            n++;
        end
        repeat (512) tick();
        checks++;
        if (sample_valid_o !== 1'b1 || overflow_o !== 1'b1 || drop_count_o !== 16'(3 * c_STATS)) begin
            fails++;
            $display("FAIL pre_disable: valid=%b ovf=%b dc=%0d, required 1 1 %0d",
                     sample_valid_o, overflow_o, drop_count_o, 3 * c_STATS);
        end
        n = 0;
        while (s != 40 && n < 700) begin
            tick();
            n++;
        end
        enable_i = 1'b0;
        tick();
        checks++;
        if (n >= 700 || state_o !== 2'd0 || sample_valid_o !== 1'b0 || overflow_o !== 1'b1 || clkgen_rst_no !== 1'b1) begin
            fails++;
            $display("FAIL disable: state=%0d valid=%b ovf=%b clkgen=%b, required 0 0 1 1",
                     state_o, sample_valid_o, overflow_o, clkgen_rst_no);
        end
        tick();
        checks++;
        if (clkgen_rst_no !== 1'b0 || frame_count_o !== 16'(5 * c_STATS)) begin
            fails++;
            $display("FAIL disable_clkgen: clkgen=%b fc=%0d, required 0 %0d",
                     clkgen_rst_no, frame_count_o, 5 * c_STATS);
        end
        repeat (5) tick();
    endtask

    task automatic test_rst_capture();
        rst_i = 1'b1;
        tick();
        checks++;
        if (state_o !== 2'd0 || clkgen_rst_no !== 1'b0 || sample_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_ctl: state=%0d clkgen=%b valid=%b ovf=%b, required 0 0 0 0",
                     state_o, clkgen_rst_no, sample_valid_o, overflow_o);
        end
        checks++;
        if (left_o !== 24'h0 || right_o !== 24'h0 || frame_count_o !== 16'h0 || drop_count_o !== 16'h0) begin
            fails++;
            $display("FAIL rst_mid_data: left=%h right=%h fc=%0d dc=%0d, required all 0",
                     left_o, right_o, frame_count_o, drop_count_o);
        end
        enable_i = 1'b0;
        rst_i    = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_enable_warmup();
        test_first_pair(24'h123456, 24'hFEDCBA);
        test_overflow();
        test_back_to_back();
        test_disable();
        // Re-enable with boundary words: full warm-up must repeat
        mic_l = 24'h800001;
        mic_r = 24'h7FFFFE;
        test_enable_warmup();
        test_first_pair(24'h800001, 24'h7FFFFE);
        // One more frame with ready low so overflow is set before reset
        repeat (520) tick();
        test_rst_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_i2s_rx_ctrl
`default_nettype wire
